msk_g16mul_sched: RTL

- Round-robin scheduler that shares one external masked HPC3 G(16) multiplier instance among N requesters.
- Arbitrates requests and gates each issue on fresh randomness from the PRNG.
- Generates the one-cycle-delayed a-sharing the multiplier needs and tracks the 1-cycle multiplier latency.
- Returns tagged results through a 2-entry output buffer with valid/ready backpressure.

---
 rtl/msk_g16mul_sched_pkg.sv | 19 +
 rtl/msk_g16mul_sched_rr_arbiter.sv | 53 +++++
 rtl/msk_g16mul_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/msk_g16mul_sched_pkg.sv
// Shared sizing helpers and share-layout helper for the masked G(16) multiplier scheduler.
package msk_g16mul_sched_pkg;

  // Fresh random bits one HPC3 G(16) multiplication consumes for d shares.
  function automatic int rnd_width(input int d);
    return 4 * d * (d - 1);
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Position of share i of nibble bit j inside a 4*d-bit masked word.
  function automatic int share_idx(input int j, input int i, input int d);
    return j * d + i;
  endfunction

endpackage

// File: rtl/msk_g16mul_sched_rr_arbiter.sv
// Round-robin arbiter: registered priority pointer, combinational one-hot grant.
// The pointer moves to the slot after the winner only when en is high.
module msk_g16mul_sched_rr_arbiter #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           gnt_any
);

  logic [IDW-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer wins; otherwise wrap to the lowest index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    gnt_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[k] && (k >= int'(ptr_q))) begin
        gnt_any   = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[k]) begin
        gnt_any   = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
  end

  // Advance the pointer past the winner on an accepted grant, wrapping modulo N.
  always_comb begin
    ptr_d = ptr_q;
    if (en && gnt_any) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/msk_g16mul_sched.sv
// Shares one external masked HPC3 G(16) multiplier among N requesters.
// Handshakes: a transfer happens on a channel in any cycle where its valid and
// ready are both high; req_ready/rnd_ready are asserted together on an issue,
// and the response holds id/data stable while resp_valid is high and resp_ready low.
// Shares are only ever moved as whole words under public selects, never combined.
module msk_g16mul_sched
  import msk_g16mul_sched_pkg::*;
#(
  parameter int d    = 2,
  parameter int N    = 3,
  parameter int IDW  = id_width(N),
  parameter int RNDW = rnd_width(d)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*4*d-1:0]  req_a,
  input  logic [N*4*d-1:0]  req_b,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [RNDW-1:0]   rnd,
  output logic [4*d-1:0]    mul_ina,
  output logic [4*d-1:0]    mul_inb,
  output logic [4*d-1:0]    mul_ina_prev,
  output logic [RNDW-1:0]   mul_rnd,
  input  logic [4*d-1:0]    mul_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [4*d-1:0]    resp_data
);

  localparam int W = 4 * d;

  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           gnt_any;
  logic           pop, push, issue;
  logic [2:0]     occ;
  logic [W-1:0]   a_sel, b_sel;

  logic           p1_valid_q, p1_valid_d;
  logic [IDW-1:0] p1_id_q, p1_id_d;
  logic [W-1:0]   a_prev_q, a_prev_d;
  logic [1:0]     count_q, count_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [W-1:0]   data_q [2];
  logic [W-1:0]   data_d [2];
  logic [IDW-1:0] id_q [2];
  logic [IDW-1:0] id_d [2];

  msk_g16mul_sched_rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (issue),
    .grant     (grant),
    .grant_idx (grant_idx),
    .gnt_any   (gnt_any)
  );

  // Issue only when randomness is fresh and the result is guaranteed a FIFO slot.
  always_comb begin
    pop   = resp_valid & resp_ready;
    push  = p1_valid_q;
    occ   = {1'b0, count_q} + {2'b00, p1_valid_q} - {2'b00, pop};
    issue = rst_n & gnt_any & rnd_valid & (occ < 3'd2);
  end

  // Whole-word operand select driven by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        a_sel = req_a[k*W +: W];
        b_sel = req_b[k*W +: W];
      end
    end
  end

  // Multiplier and handshake outputs; everything idles at zero without an issue.
  always_comb begin
    req_ready    = issue ? grant : '0;
    rnd_ready    = issue;
    mul_ina      = issue ? a_sel : '0;
    mul_inb      = issue ? b_sel : '0;
    mul_rnd      = issue ? rnd : '0;
    mul_ina_prev = a_prev_q;
    resp_valid   = (count_q != 2'd0);
    resp_id      = id_q[rd_ptr_q];
    resp_data    = data_q[rd_ptr_q];
  end

  // Next state: multiplier pipeline tag, delayed a-sharing and the 2-entry result FIFO.
  always_comb begin
    p1_valid_d = issue;
    p1_id_d    = issue ? grant_idx : p1_id_q;
    a_prev_d   = issue ? a_sel : '0;
    data_d     = data_q;
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = mul_out;
      id_d[wr_ptr_q]   = p1_id_q;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_q <= 1'b0;
      p1_id_q    <= '0;
      a_prev_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      data_q     <= '{default: '0};
      id_q       <= '{default: '0};
    end else begin
      p1_valid_q <= p1_valid_d;
      p1_id_q    <= p1_id_d;
      a_prev_q   <= a_prev_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      id_q       <= id_d;
    end
  end

  // The occupancy gate reserves a slot at issue time, so a push never meets a full FIFO.
  push_into_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(p1_valid_q && (count_q == 2'd2)));

endmodule
